// File: rtl/letc_core_limp_arbiter_pkg.sv
// Shared LETC core types used on LIMP request/response ports.
package letc_core_limp_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [33:0] paddr_t;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALFWORD = 2'b01,
        SIZE_WORD     = 2'b10
    } size_e;

    // Index width that stays legal (>=1 bit) for any requestor count.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/letc_core_rr_arbiter.sv
// Rotating-priority search: first set request at or after start, wrapping.
module letc_core_rr_arbiter
    import letc_core_limp_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    int            j;
    logic [IW-1:0] jj;

    // Walk offsets from the far end so the nearest requestor is written last.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        j     = 0;
        jj    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j  = (int'(start_i) + k) % N;
            jj = IW'(j);
            if (req_i[jj]) begin
                idx_o = jj;
            end
        end
    end

endmodule

// File: rtl/letc_core_limp_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ LIMP requestors onto one servicer.
module letc_core_limp_arbiter
    import letc_core_limp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] req_wen_nren,
    input  logic [NUM_REQ-1:0] req_uncacheable,
    input  size_e              req_size  [NUM_REQ],
    input  paddr_t             req_addr  [NUM_REQ],
    input  word_t              req_wdata [NUM_REQ],
    output word_t              req_rdata [NUM_REQ],

    output logic               srv_valid,
    output logic               srv_wen_nren,
    output logic               srv_uncacheable,
    output size_e              srv_size,
    output paddr_t             srv_addr,
    output word_t              srv_wdata,
    input  logic               srv_ready,
    input  word_t              srv_rdata
);

    localparam int IW = idx_w(NUM_REQ);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] rr_q, rr_d;
    logic          arb_any;
    logic [IW-1:0] arb_idx;
    logic          busy;
    logic          done;

    letc_core_rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req_i  (req_valid),
        .start_i(rr_q),
        .any_o  (arb_any),
        .idx_o  (arb_idx)
    );

    assign busy = (state_q == BUSY);
    assign done = srv_valid & srv_ready;

    always_comb begin
        srv_valid       = busy & req_valid[gnt_q];
        srv_wen_nren    = req_wen_nren[gnt_q];
        srv_uncacheable = req_uncacheable[gnt_q];
        srv_size        = req_size[gnt_q];
        srv_addr        = req_addr[gnt_q];
        srv_wdata       = req_wdata[gnt_q];
        req_ready       = '0;
        if (busy) begin
            req_ready[gnt_q] = srv_ready;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdata[i] = srv_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = BUSY;
                    gnt_d   = arb_idx;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    rr_d    = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

`ifdef SIMULATION
    // The granted requestor must keep its request up until it sees ready.
    always_ff @(posedge i_clk) begin
        if (!i_rst && busy) begin
            assert (req_valid[gnt_q])
            else $error("granted requestor dropped req_valid before completion");
        end
    end
`endif

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Bench for the LIMP round-robin arbiter with four requestors.
module tb_letc_core_limp_arbiter;
    import letc_core_limp_arbiter_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_wen = '0;
    logic [N-1:0] req_unc = '0;
    size_e        req_size  [N];
    paddr_t       req_addr  [N];
    word_t        req_wdata [N];
    word_t        req_rdata [N];
    logic         srv_valid;
    logic         srv_wen_nren;
    logic         srv_uncacheable;
    size_e        srv_size;
    paddr_t       srv_addr;
    word_t        srv_wdata;
    logic         srv_ready = 1'b0;
    word_t        srv_rdata = '0;

    int checks = 0;
    int errors = 0;

    letc_core_limp_arbiter #(
        .NUM_REQ(N)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen_nren   (req_wen),
        .req_uncacheable(req_unc),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rdata      (req_rdata),
        .srv_valid      (srv_valid),
        .srv_wen_nren   (srv_wen_nren),
        .srv_uncacheable(srv_uncacheable),
        .srv_size       (srv_size),
        .srv_addr       (srv_addr),
        .srv_wdata      (srv_wdata),
        .srv_ready      (srv_ready),
        .srv_rdata      (srv_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        srv_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int ohidx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Hold mask valid with the servicer always ready; compare each grant
    // against the expected sequence packed one nibble per transaction.
    task automatic run_cont(input string name, input logic [N-1:0] mask,
                            input int n, input logic [31:0] seq);
        int got;
        int cyc;
        got       = 0;
        cyc       = 0;
        req_valid = mask;
        srv_ready = 1'b1;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check($sformatf("%s grant %0d", name, got),
                      64'(ohidx(req_ready)), 64'(seq[4*got +: 4]));
                got++;
            end
            tick();
            cyc++;
        end
        check($sformatf("%s grant count", name), 64'(got), 64'(n));
        req_valid = '0;
        srv_ready = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        int           gnt;
    } vec_t;

    vec_t tbl [10];

    logic         m_busy;
    int           m_gnt;
    int           m_rr;
    int           waited [N];
    logic [N-1:0] done_mask;
    logic [N-1:0] exp_rdy;
    int           g;
    logic         rd_ok;

    initial begin
        // Sequential arbitration table starting from reset (pointer 0).
        tbl[0] = '{4'b0001, 0};
        tbl[1] = '{4'b0001, 0};
        tbl[2] = '{4'b1001, 3};
        tbl[3] = '{4'b1010, 1};
        tbl[4] = '{4'b0011, 0};
        tbl[5] = '{4'b1100, 2};
        tbl[6] = '{4'b0111, 0};
        tbl[7] = '{4'b1111, 1};
        tbl[8] = '{4'b0100, 2};
        tbl[9] = '{4'b1000, 3};

        for (int i = 0; i < N; i++) begin
            req_size[i]  = SIZE_WORD;
            req_addr[i]  = 34'h1000 + 34'(i * 'h100);
            req_wdata[i] = 32'hA000_0000 + 32'(i);
        end

        do_reset();
        @(negedge clk);
        check("reset srv_valid", 64'(srv_valid), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);

        // Single read from requestor 0, servicer ready on the second busy cycle.
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        check("r0 arb cycle srv_valid", 64'(srv_valid), 64'd0);
        tick();
        @(negedge clk);
        check("r0 srv_valid", 64'(srv_valid), 64'd1);
        check("r0 srv_addr", 64'(srv_addr), 64'h1000);
        check("r0 srv_wen", 64'(srv_wen_nren), 64'd0);
        check("r0 req_ready wait", 64'(req_ready), 64'd0);
        tick();
        srv_ready = 1'b1;
        srv_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("r0 req_ready", 64'(req_ready), 64'b0001);
        check("r0 rdata", 64'(req_rdata[0]), 64'hDEAD_BEEF);
        tick();
        req_valid = '0;
        srv_ready = 1'b0;
        @(negedge clk);
        check("r0 back to idle", 64'(srv_valid), 64'd0);
        tick();
        req_valid = 4'b0011;
        tick();
        srv_ready = 1'b1;
        @(negedge clk);
        check("r0 pointer moved to 1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        srv_ready = 1'b0;

        do_reset();
        for (int k = 0; k < 10; k++) begin
            req_valid = tbl[k].valid;
            srv_ready = 1'b0;
            @(negedge clk);
            check($sformatf("tbl%0d idle", k), 64'(srv_valid), 64'd0);
            tick();
            srv_ready = 1'b1;
            @(negedge clk);
            check($sformatf("tbl%0d grant", k), 64'(ohidx(req_ready)),
                  64'(tbl[k].gnt));
            check($sformatf("tbl%0d addr", k), 64'(srv_addr),
                  64'(req_addr[tbl[k].gnt]));
            tick();
            req_valid = '0;
            srv_ready = 1'b0;
        end

        do_reset();
        run_cont("both", 4'b0011, 2, 32'h10);
        do_reset();
        run_cont("alternate", 4'b0011, 4, 32'h1010);
        do_reset();
        run_cont("all4", 4'b1111, 5, 32'h03210);

        // Stalled byte write from requestor 1.
        do_reset();
        req_wen[1]   = 1'b1;
        req_unc[1]   = 1'b1;
        req_size[1]  = SIZE_BYTE;
        req_addr[1]  = 34'h2_0000_2004;
        req_wdata[1] = 32'h1234_5678;
        req_valid    = 4'b0010;
        tick();
        for (int c = 0; c < 6; c++) begin
            srv_ready = (c == 5);
            @(negedge clk);
            check($sformatf("stall c%0d ctl", c),
                  64'({srv_valid, srv_wen_nren, srv_uncacheable, srv_size, srv_addr}),
                  64'({1'b1, 1'b1, 1'b1, SIZE_BYTE, 34'h2_0000_2004}));
            check($sformatf("stall c%0d wdata", c), 64'(srv_wdata), 64'h1234_5678);
            check($sformatf("stall c%0d ready", c), 64'(req_ready),
                  (c == 5) ? 64'b0010 : 64'd0);
            tick();
        end
        req_valid = '0;
        srv_ready = 1'b0;
        @(negedge clk);
        check("stall done idle", 64'(srv_valid), 64'd0);
        tick();

        // Reset in the middle of a transfer.
        do_reset();
        req_valid = 4'b0001;
        tick();
        srv_ready = 1'b1;
        tick();
        req_valid = 4'b0010;
        srv_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk);
        check("midrst srv_valid", 64'(srv_valid), 64'd0);
        check("midrst req_ready", 64'(req_ready), 64'd0);
        tick();
        srv_ready = 1'b1;
        @(negedge clk);
        check("midrst pointer cleared", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        srv_ready = 1'b0;

        // Random traffic against a transaction-level model.
        do_reset();
        m_busy = 1'b0;
        m_gnt  = 0;
        m_rr   = 0;
        for (int i = 0; i < N; i++) waited[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_wen[i]   = 1'($urandom_range(1));
                    req_unc[i]   = 1'($urandom_range(1));
                    req_size[i]  = size_e'($urandom_range(2));
                    req_addr[i]  = paddr_t'({$urandom, $urandom});
                    req_wdata[i] = $urandom;
                    waited[i]    = 0;
                end
            end
            srv_ready = 1'($urandom_range(1));
            srv_rdata = $urandom;
            @(negedge clk);
            exp_rdy = '0;
            if (m_busy && srv_ready) exp_rdy[m_gnt] = 1'b1;
            check("rnd srv_valid", 64'(srv_valid), 64'(m_busy));
            check("rnd req_ready", 64'(req_ready), 64'(exp_rdy));
            if (m_busy) begin
                check("rnd ctl",
                      64'({srv_wen_nren, srv_uncacheable, srv_size, srv_addr}),
                      64'({req_wen[m_gnt], req_unc[m_gnt], req_size[m_gnt],
                           req_addr[m_gnt]}));
                check("rnd wdata", 64'(srv_wdata), 64'(req_wdata[m_gnt]));
            end
            rd_ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (req_rdata[i] !== srv_rdata) rd_ok = 1'b0;
            end
            check("rnd rdata fanout", 64'(rd_ok), 64'd1);

            done_mask = '0;
            if (m_busy) begin
                if (srv_ready) begin
                    done_mask[m_gnt] = 1'b1;
                    m_busy = 1'b0;
                    m_rr   = (m_gnt + 1) % N;
                end
            end else if (req_valid != '0) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
                check("rnd starvation bound", 64'(waited[g] < N), 64'd1);
                for (int i = 0; i < N; i++) begin
                    if (i != g && req_valid[i]) waited[i]++;
                end
                waited[g] = 0;
                m_gnt     = g;
                m_busy    = 1'b1;
            end
            tick();
            req_valid = req_valid & ~done_mask;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
